// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and helpers for the pipelined carry-lookahead adder.
//   CLA_GROUP  - default number of bits per lookahead group
//   cla_stages - number of pipeline stages (one group per stage)
//   cla_cfg_ok - true when WIDTH is a non-zero multiple of GROUP
package cla_pkg;

  localparam int CLA_GROUP = 4;

  function automatic int cla_stages(input int width, input int group);
    return width / group;
  endfunction

  function automatic bit cla_cfg_ok(input int width, input int group);
    return (group > 0) && (width >= group) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: G-bit combinational carry-lookahead adder.
//   a, b  - G-bit operands
//   cin   - carry into bit 0
//   sum   - G-bit sum
//   cout  - carry out of bit G-1
//   cmsb  - carry into bit G-1 (used for signed overflow of the top group)
module cla_group #(
  parameter int G = 4
) (
  input  logic [G-1:0] a,
  input  logic [G-1:0] b,
  input  logic         cin,
  output logic [G-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic [G-1:0] g;
  logic [G-1:0] p;
  logic [G:0]   c;
  logic         acc;
  logic         run;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products: c[i+1] = g[i] | p[i]g[i-1] | ...
  // | p[i]..p[0]cin. The inner loop walks down from bit i accumulating the
  // propagate product, so no carry depends on another computed carry.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    run  = 1'b1;
    c[0] = cin;
    for (int i = 0; i < G; i++) begin
      acc = 1'b0;
      run = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (run & g[j]);
        run = run & p[j];
      end
      c[i+1] = acc | (run & cin);
    end
  end

  assign sum  = p ^ c[G-1:0];
  assign cout = c[G];
  assign cmsb = c[G-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined WIDTH-bit carry-lookahead adder/subtractor.
// One GROUP-bit lookahead group is resolved per stage; the group carry is
// registered between stages. Latency is STAGES = WIDTH/GROUP register stages.
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - operation handshake (A, B, Cin, Sub)
//   out_valid/out_ready  - result handshake (Sum, Cout, Ovf)
//   Sub=0: A+B+Cin;  Sub=1: A-B (Cin ignored, Cout=1 means no borrow)
//   Ovf = carry into MSB xor carry out of MSB
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// whole pipe advances together when enable = !out_valid || out_ready, and
// in_ready equals that enable, so it never depends on in_valid. When the pipe
// holds, every stage register (data and valid) keeps its value.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int STAGES = cla_stages(WIDTH, GROUP);

  if (!cla_cfg_ok(WIDTH, GROUP)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  // Stage registers. a_q/b_q carry the (already inverted for Sub) operands so
  // later stages can pick their slices; s_q accumulates finished sum bits.
  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] s_q;
  logic [STAGES-1:0]            c_q;
  logic                         ovf_q;

  // Per-stage inputs and next values.
  logic [STAGES-1:0]            v_in;
  logic [STAGES-1:0][WIDTH-1:0] a_in;
  logic [STAGES-1:0][WIDTH-1:0] b_in;
  logic [STAGES-1:0][WIDTH-1:0] s_in;
  logic [STAGES-1:0]            c_in;
  logic [STAGES-1:0][WIDTH-1:0] s_nxt;
  logic [STAGES-1:0]            c_nxt;
  logic [STAGES-1:0]            cm_nxt;
  logic                         ovf_nxt;
  logic                         en;

  assign en       = !v_q[STAGES-1] || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [GROUP-1:0] grp_sum;

    if (k == 0) begin : g_first
      assign v_in[0] = in_valid;
      assign a_in[0] = A;
      assign b_in[0] = B ^ {WIDTH{Sub}};
      assign s_in[0] = '0;
      assign c_in[0] = Sub | Cin;
    end else begin : g_next
      assign v_in[k] = v_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign c_in[k] = c_q[k-1];
    end

    cla_group #(.G(GROUP)) u_group (
      .a    (a_in[k][k*GROUP +: GROUP]),
      .b    (b_in[k][k*GROUP +: GROUP]),
      .cin  (c_in[k]),
      .sum  (grp_sum),
      .cout (c_nxt[k]),
      .cmsb (cm_nxt[k])
    );

    // Bits at and above this group's slice are still zero in s_in, so the
    // new slice can simply be OR-ed into place.
    assign s_nxt[k] = s_in[k] | (WIDTH'(grp_sum) << (k * GROUP));
  end

  assign ovf_nxt = cm_nxt[STAGES-1] ^ c_nxt[STAGES-1];

  // Data registers load only with a valid operation so the outputs keep the
  // last result (or the reset zeros) while bubbles pass through.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      v_q <= v_in;
      for (int k = 0; k < STAGES; k++) begin
        if (v_in[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= s_nxt[k];
          c_q[k] <= c_nxt[k];
        end
      end
      if (v_in[STAGES-1]) ovf_q <= ovf_nxt;
    end
  end

  // Operands are fully consumed by the last stage and intermediate MSB
  // carries only matter for the top group.
  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], cm_nxt};

  assign out_valid = v_q[STAGES-1];
  assign Sum       = s_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed self-checking bench for cla_pipe_adder at the
// default WIDTH=16, GROUP=4 (four stages).
module tb_cla_pipe_adder;

  localparam int WIDTH = 16;
  localparam int W     = WIDTH + 2;  // {Cout, Ovf, Sum}

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic set_op(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub);
    A = a; B = b; Cin = cin; Sub = sub;
  endtask

  // Present one operation and return #1 after the edge that accepts it.
  task automatic drive_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
    set_op(a, b, cin, sub);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid rises, bounded.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (Sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h exp=0000", Sum); end
    checks++;
    if ({Cout, Ovf} !== 2'b00) begin errors++; $display("FAIL reset_cout_ovf got=%b exp=00", {Cout, Ovf}); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
  endtask

  // Single operation: latency of 3 edges after the accept edge, then result.
  task automatic one_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input logic [W-1:0] exp);
    int cyc;
    drive_op(a, b, cin, sub);
    wait_out(cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("FAIL %s_latency got=%0d exp=3", name, cyc); end
    checks++;
    if ({Cout, Ovf, Sum} !== exp) begin
      errors++;
      $display("FAIL %s got C=%b V=%b S=%h exp C=%b V=%b S=%h", name, Cout, Ovf, Sum,
               exp[W-1], exp[W-2], exp[WIDTH-1:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    one_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
    one_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    one_op("add_cin",    16'h1234, 16'h0FFF, 1'b1, 1'b0, {1'b0, 1'b0, 16'h2234});
  endtask

  task automatic test_sub();
    one_op("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    one_op("sub_1_2_cin", 16'h0001, 16'h0002, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFF});
    one_op("sub_equal",  16'h5555, 16'h5555, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0000});
  endtask

  task automatic test_back_to_back();
    logic [15:0] va[8];
    logic [15:0] vb[8];
    logic        vc[8];
    logic        vs[8];
    logic [W-1:0] ve[8];
    int n_out, first_cyc, last_cyc;
    va[0] = 16'hA5A5; vb[0] = 16'h5A5A; vc[0] = 1; vs[0] = 0; ve[0] = {2'b10, 16'h0000};
    va[1] = 16'h00FF; vb[1] = 16'h0001; vc[1] = 0; vs[1] = 0; ve[1] = {2'b00, 16'h0100};
    va[2] = 16'h0FFF; vb[2] = 16'h0001; vc[2] = 0; vs[2] = 0; ve[2] = {2'b00, 16'h1000};
    va[3] = 16'h8000; vb[3] = 16'h8000; vc[3] = 0; vs[3] = 0; ve[3] = {2'b11, 16'h0000};
    va[4] = 16'h1234; vb[4] = 16'h4321; vc[4] = 1; vs[4] = 0; ve[4] = {2'b00, 16'h5556};
    va[5] = 16'h0000; vb[5] = 16'h0001; vc[5] = 0; vs[5] = 1; ve[5] = {2'b00, 16'hFFFF};
    va[6] = 16'h7FFF; vb[6] = 16'hFFFF; vc[6] = 0; vs[6] = 1; ve[6] = {2'b01, 16'h8000};
    va[7] = 16'h1000; vb[7] = 16'h0001; vc[7] = 1; vs[7] = 1; ve[7] = {2'b10, 16'h0FFF};
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(ve[i]);
    out_ready = 1'b1;
    n_out = 0; first_cyc = -1; last_cyc = -1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          set_op(va[i], vb[i], vc[i], vs[i]);
          in_valid = 1'b1;
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int cyc = 1; cyc <= 14; cyc++) begin
          @(posedge clk); #1;
          if (out_valid) begin
            logic [W-1:0] e;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            n_out++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            checks++;
            if ({Cout, Ovf, Sum} !== e) begin
              errors++;
              $display("FAIL b2b_result_%0d got=%h exp=%h", n_out, {Cout, Ovf, Sum}, e);
            end
          end
        end
      end
    join
    checks++;
    if (n_out !== 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", n_out); end
    checks++;
    if (first_cyc !== 4) begin errors++; $display("FAIL b2b_first_cycle got=%0d exp=4", first_cyc); end
    checks++;
    if (last_cyc !== 11) begin errors++; $display("FAIL b2b_last_cycle got=%0d exp=11", last_cyc); end
  endtask

  task automatic test_stall();
    logic [15:0] va[5];
    logic [15:0] vb[5];
    logic        vs[5];
    logic [W-1:0] ve[5];
    logic [W-1:0] e;
    int n_out;
    va[0] = 16'h0003; vb[0] = 16'h0004; vs[0] = 0; ve[0] = {2'b00, 16'h0007};
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vs[1] = 0; ve[1] = {2'b10, 16'hFFFE};
    va[2] = 16'h0010; vb[2] = 16'h0020; vs[2] = 1; ve[2] = {2'b00, 16'hFFF0};
    va[3] = 16'h4000; vb[3] = 16'h4000; vs[3] = 0; ve[3] = {2'b01, 16'h8000};
    va[4] = 16'h8000; vb[4] = 16'h7FFF; vs[4] = 1; ve[4] = {2'b11, 16'h0001};
    exp_q.delete();
    for (int i = 1; i < 5; i++) exp_q.push_back(ve[i]);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(va[i], vb[i], 1'b0, vs[i]);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    // Pipe full, op0 on the outputs; stall with op4 waiting at the input.
    set_op(va[4], vb[4], 1'b0, vs[4]);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_%0d got=%b exp=0", i, in_ready); end
      checks++;
      if ({out_valid, Cout, Ovf, Sum} !== {1'b1, ve[0]}) begin
        errors++;
        $display("FAIL stall_hold_%0d got=%b/%h exp=1/%h", i, out_valid, {Cout, Ovf, Sum}, ve[0]);
      end
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, Cout, Ovf, Sum} !== {2'b11, ve[0]}) begin
      errors++;
      $display("FAIL stall_release got=%b%b/%h exp=11/%h", in_ready, out_valid, {Cout, Ovf, Sum}, ve[0]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_out = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_out++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        checks++;
        if ({Cout, Ovf, Sum} !== e) begin
          errors++;
          $display("FAIL stall_drain_%0d got=%h exp=%h", n_out, {Cout, Ovf, Sum}, e);
        end
      end
    end
    checks++;
    if (n_out !== 4) begin errors++; $display("FAIL stall_drain_count got=%0d exp=4", n_out); end
  endtask

  task automatic test_reset_flight();
    int seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(16'h0100 + 16'(i), 16'h0001, 1'b0, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (Sum !== 16'h0000) begin errors++; $display("FAIL flush_sum got=%h exp=0000", Sum); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL flush_no_result got=%0d exp=0", seen); end
    one_op("after_flush", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, {2'b00, 16'h1000});
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
